utf8_stream_decoder: RTL and testbench

UTF8_STREAM_DECODER -- requirements
Module: utf8_stream_decoder

---
 rtl/utf8_pkg.sv | 79 +++++++
 rtl/utf8_stream_decoder_if.sv | 25 ++
 rtl/utf8_lead_classify.sv | 28 ++
 rtl/utf8_stream_decoder.sv | 147 ++++++++++++++
 tb/tb_utf8_stream_decoder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/utf8_pkg.sv
// Shared types and constants for the UTF-8 stream decoder.
// UTF8_LEGACY_SEQ_EN widens the datapath for 5- and 6-byte legacy sequences.
package utf8_pkg;

`ifdef UTF8_LEGACY_SEQ_EN
  localparam int CNT_W = 3;
  localparam int PAY_W = 31;
`else
  localparam int CNT_W = 2;
  localparam int PAY_W = 21;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONT = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_ASCII   = 3'd0,
    CLS_CONT    = 3'd1,
    CLS_LEAD2   = 3'd2,
    CLS_LEAD3   = 3'd3,
    CLS_LEAD4   = 3'd4,
    CLS_LEAD5   = 3'd5,
    CLS_LEAD6   = 3'd6,
    CLS_ILLEGAL = 3'd7
  } lead_class_t;

  typedef struct packed {
    logic [31:0] cp;
    logic        invalid;
    logic        overlong;
    logic        truncated;
    logic        nonuni;
  } out_rec_t;

  // Smallest value that legitimately needs a sequence of the given length.
  localparam logic [31:0] OVL_MIN2 = 32'h0000_0080;
  localparam logic [31:0] OVL_MIN3 = 32'h0000_0800;
  localparam logic [31:0] OVL_MIN4 = 32'h0001_0000;
  localparam logic [31:0] OVL_MIN5 = 32'h0020_0000;
  localparam logic [31:0] OVL_MIN6 = 32'h0400_0000;
  localparam logic [31:0] UNI_MAX  = 32'h0010_FFFF;

  function automatic logic [31:0] ovl_min(input logic [2:0] len);
    case (len)
      3'd2:    return OVL_MIN2;
      3'd3:    return OVL_MIN3;
      3'd4:    return OVL_MIN4;
      3'd5:    return OVL_MIN5;
      3'd6:    return OVL_MIN6;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] lead_mask(input logic [2:0] len);
    case (len)
      3'd2:    return 8'h1F;
      3'd3:    return 8'h0F;
      3'd4:    return 8'h07;
      3'd5:    return 8'h03;
      3'd6:    return 8'h01;
      default: return 8'h7F;
    endcase
  endfunction

  function automatic logic is_nonuni(input logic [31:0] v, input logic [2:0] len);
    logic surr;
    surr = (v >= 32'h0000_D800) && (v <= 32'h0000_DFFF);
    case (len)
      3'd3:       return surr;
      3'd4:       return v > UNI_MAX;
      3'd5, 3'd6: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/utf8_stream_decoder_if.sv
// Byte-in / code-point-out stream bundle for the UTF-8 decoder.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface utf8_stream_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_cp;
  logic        out_invalid;
  logic        out_overlong;
  logic        out_truncated;
  logic        out_nonuni;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_cp, out_invalid, out_overlong, out_truncated, out_nonuni
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_cp, out_invalid, out_overlong, out_truncated, out_nonuni
  );
endinterface

// File: rtl/utf8_lead_classify.sv
// Combinational byte classifier: ASCII, continuation, lead of length N, or illegal.
// Lead bytes F8-FD are only recognised when UTF8_LEGACY_SEQ_EN is defined.
module utf8_lead_classify
  import utf8_pkg::*;
(
  input  logic [7:0]  byte_in,
  output lead_class_t cls,
  output logic [2:0]  seq_len
);

  always_comb begin
    cls     = CLS_ILLEGAL;
    seq_len = 3'd1;
    casez (byte_in)
      8'b0???????: begin cls = CLS_ASCII; seq_len = 3'd1; end
      8'b10??????: begin cls = CLS_CONT;  seq_len = 3'd1; end
      8'b110?????: begin cls = CLS_LEAD2; seq_len = 3'd2; end
      8'b1110????: begin cls = CLS_LEAD3; seq_len = 3'd3; end
      8'b11110???: begin cls = CLS_LEAD4; seq_len = 3'd4; end
`ifdef UTF8_LEGACY_SEQ_EN
      8'b111110??: begin cls = CLS_LEAD5; seq_len = 3'd5; end
      8'b1111110?: begin cls = CLS_LEAD6; seq_len = 3'd6; end
`endif
      default:     begin cls = CLS_ILLEGAL; seq_len = 3'd1; end
    endcase
  end

endmodule

// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 to code point decoder with IDLE/CONT/PEND FSM and a one-entry output register.
// Define UTF8_LEGACY_SEQ_EN to accept 5- and 6-byte legacy sequences.
module utf8_stream_decoder
  import utf8_pkg::*;
#(
  parameter logic [31:0] REPL_CP = 32'h0000FFFD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  utf8_stream_decoder_if.slave bus,
  output state_t               dbg_state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       len_q, len_d;
  logic [PAY_W-1:0] acc_q, acc_d, acc_shift;
  logic [7:0]       pend_q, pend_d;
  logic             flush_pend_q, flush_pend_d;
  logic             out_valid_q;
  out_rec_t         out_q;

  logic             emit;
  out_rec_t         emit_rec;
  lead_class_t      cls;
  logic [2:0]       cls_len;
  logic [7:0]       cls_byte;
  logic             slot_free, in_xfer, do_lead, do_cont, flush_req;
  logic [31:0]      done_val;

  assign slot_free    = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = rst_n & (state_q != ST_PEND) & slot_free;
  assign in_xfer      = bus.in_valid & bus.in_ready;

  // A byte parked in PEND is reclassified exactly as if it had just arrived in IDLE.
  assign cls_byte  = (state_q == ST_PEND) ? pend_q : bus.in_data;
  assign do_lead   = ((state_q == ST_IDLE) && in_xfer) || ((state_q == ST_PEND) && slot_free);
  assign do_cont   = (state_q == ST_CONT) && in_xfer;
  assign flush_req = bus.flush | flush_pend_q;
  assign acc_shift = PAY_W'({acc_q, bus.in_data[5:0]});
  assign done_val  = 32'(acc_shift);

  utf8_lead_classify u_classify (
    .byte_in (cls_byte),
    .cls     (cls),
    .seq_len (cls_len)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    acc_d        = acc_q;
    pend_d       = pend_q;
    flush_pend_d = 1'b0;
    emit         = 1'b0;
    emit_rec     = '0;

    if (do_lead) begin
      state_d = ST_IDLE;
      case (cls)
        CLS_ASCII: begin
          emit        = 1'b1;
          emit_rec.cp = {24'h0, cls_byte};
        end
        CLS_LEAD2, CLS_LEAD3, CLS_LEAD4, CLS_LEAD5, CLS_LEAD6: begin
          state_d = ST_CONT;
          cnt_d   = CNT_W'(cls_len - 3'd1);
          len_d   = cls_len;
          acc_d   = PAY_W'(cls_byte & lead_mask(cls_len));
        end
        default: begin
          emit             = 1'b1;
          emit_rec.cp      = REPL_CP;
          emit_rec.invalid = 1'b1;
        end
      endcase
    end else if (do_cont) begin
      if (cls == CLS_CONT) begin
        acc_d = acc_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d           = ST_IDLE;
          emit              = 1'b1;
          emit_rec.cp       = done_val;
          emit_rec.overlong = done_val < ovl_min(len_q);
          emit_rec.nonuni   = is_nonuni(done_val, len_q);
        end
      end else begin
        state_d            = ST_PEND;
        pend_d             = bus.in_data;
        emit               = 1'b1;
        emit_rec.cp        = REPL_CP;
        emit_rec.truncated = 1'b1;
      end
    end

    // Flush acts on the post-byte state; if the output slot is busy it waits in flush_pend.
    if ((state_q == ST_CONT) && (state_d == ST_CONT) && flush_req) begin
      if (slot_free) begin
        state_d            = ST_IDLE;
        emit               = 1'b1;
        emit_rec           = '0;
        emit_rec.cp        = REPL_CP;
        emit_rec.truncated = 1'b1;
      end else begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      pend_q       <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      flush_pend_q <= flush_pend_d;
      if (emit) begin
        out_valid_q <= 1'b1;
        out_q       <= emit_rec;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_cp        = out_q.cp;
  assign bus.out_invalid   = out_q.invalid;
  assign bus.out_overlong  = out_q.overlong;
  assign bus.out_truncated = out_q.truncated;
  assign bus.out_nonuni    = out_q.nonuni;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Directed bench for utf8_stream_decoder: sequence-level reference decoder feeding an expected queue,
// an output compare process, and literal checks on the key corner cases.
module tb_utf8_stream_decoder;
  import utf8_pkg::*;

  localparam logic [31:0] REPL = 32'h0000FFFD;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     vec[$];
  logic [35:0] exp_q[$];

  utf8_stream_decoder_if bus();

  utf8_stream_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [35:0] rec(input logic [31:0] cp, input logic inv, input logic ovl,
                                      input logic trn, input logic nu);
    return {cp, inv, ovl, trn, nu};
  endfunction

  function automatic logic [35:0] dut_rec();
    return {bus.out_cp, bus.out_invalid, bus.out_overlong, bus.out_truncated, bus.out_nonuni};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference decoder over a whole vector; negative entries mark a flush pulse.
  function automatic void model_vec();
    int i, j, k, len, b;
    logic [31:0] val, vmin;
    logic nu;
    i = 0;
    while (i < vec.size()) begin
      b = vec[i];
      if (b < 0) begin
        i++;
        continue;
      end
      if (b < 'h80) len = 1;
      else if (b < 'hC0) len = 0;
      else if (b < 'hE0) len = 2;
      else if (b < 'hF0) len = 3;
      else if (b < 'hF8) len = 4;
      else len = 0;
      if (len == 1) begin
        exp_q.push_back(rec(32'(b), 1'b0, 1'b0, 1'b0, 1'b0));
        i++;
      end else if (len == 0) begin
        exp_q.push_back(rec(REPL, 1'b1, 1'b0, 1'b0, 1'b0));
        i++;
      end else begin
        val = 32'(b & ((1 << (7 - len)) - 1));
        j = i + 1;
        k = 1;
        while (k < len && j < vec.size() && vec[j] >= 0 && (vec[j] & 'hC0) == 'h80) begin
          val = (val << 6) | 32'(vec[j] & 'h3F);
          j++;
          k++;
        end
        if (k == len) begin
          vmin = (len == 2) ? 32'h80 : (len == 3) ? 32'h800 : 32'h10000;
          nu = (len == 4 && val > 32'h10FFFF) || (len == 3 && val >= 32'hD800 && val <= 32'hDFFF);
          exp_q.push_back(rec(val, 1'b0, val < vmin, 1'b0, nu));
          i = j;
        end else if (j >= vec.size()) begin
          i = j;
        end else begin
          exp_q.push_back(rec(REPL, 1'b0, 1'b0, 1'b1, 1'b0));
          i = (vec[j] < 0) ? j + 1 : j;
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic run_vec();
    model_vec();
    foreach (vec[i]) begin
      if (vec[i] < 0) pulse_flush();
      else send_byte(8'(vec[i]));
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got=%0h expected=none", dut_rec());
      end else begin
        chk("stream_output", 64'(dut_rec()), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Pin the reference decoder against hand-decoded values.
    vec = '{'hE2, 'h82, 'hAC, 'hC0, 'h80, 'hF0, 'h9F, -1};
    model_vec();
    chk("model_pin_euro", 64'(exp_q[0]), 64'(rec(32'h20AC, 1'b0, 1'b0, 1'b0, 1'b0)));
    chk("model_pin_overlong", 64'(exp_q[1]), 64'(rec(32'h0, 1'b0, 1'b1, 1'b0, 1'b0)));
    chk("model_pin_trunc", 64'(exp_q[2]), 64'(rec(REPL, 1'b0, 1'b0, 1'b1, 1'b0)));
    exp_q.delete();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_rec", 64'(dut_rec()), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // ASCII back-to-back throughput
    c0 = cyc;
    vec = '{'h41, 'h42, 'h43};
    run_vec();
    chk("ascii_rate_cycles", 64'(cyc - c0), 64'(3));

    // Euro sign, latency one cycle after the final byte
    vec = '{'hE2, 'h82, 'hAC};
    run_vec();
    @(negedge clk);
    chk("euro_valid", 64'(bus.out_valid), 64'(1));
    chk("euro_rec", 64'(dut_rec()), 64'(rec(32'h20AC, 1'b0, 1'b0, 1'b0, 1'b0)));
    step();

    // Overlong NUL
    vec = '{'hC0, 'h80};
    run_vec();
    @(negedge clk);
    chk("c080_rec", 64'(dut_rec()), 64'(rec(32'h0, 1'b0, 1'b1, 1'b0, 1'b0)));
    step();

    // Truncation by a non-continuation byte, PEND replay
    vec = '{'hE2, 'h82, 'h41};
    run_vec();
    @(negedge clk);
    chk("pend_trunc_rec", 64'(dut_rec()), 64'(rec(REPL, 1'b0, 1'b0, 1'b1, 1'b0)));
    chk("pend_in_ready", 64'(bus.in_ready), 64'(0));
    chk("pend_state", 64'(dbg_state), 64'(ST_PEND));
    @(negedge clk);
    chk("pend_replay_rec", 64'(dut_rec()), 64'(rec(32'h41, 1'b0, 1'b0, 1'b0, 1'b0)));
    step();

    // Out-of-range and surrogate
    vec = '{'hF4, 'h90, 'h80, 'h80};
    run_vec();
    @(negedge clk);
    chk("f490_rec", 64'(dut_rec()), 64'(rec(32'h110000, 1'b0, 1'b0, 1'b0, 1'b1)));
    step();
    vec = '{'hED, 'hA0, 'h80};
    run_vec();
    @(negedge clk);
    chk("surrogate_rec", 64'(dut_rec()), 64'(rec(32'hD800, 1'b0, 1'b0, 1'b0, 1'b1)));
    step();

    // Mixed errors, overlong 3-byte, 4-byte, truncation by a lead byte
    vec = '{'h80, 'hFF, 'hF8, 'hC3, 'hA9, 'hE0, 'h80, 'h80,
            'hF0, 'h9F, 'h98, 'h80, 'hE2, 'hC3, 'hA9};
    run_vec();
    step();

    // Flush mid-sequence
    vec = '{'hF0, 'h9F, -1};
    run_vec();
    @(negedge clk);
    chk("flush_rec", 64'(dut_rec()), 64'(rec(REPL, 1'b0, 1'b0, 1'b1, 1'b0)));
    chk("flush_state", 64'(dbg_state), 64'(ST_IDLE));
    step();

    // Backpressure: output held, no input accepted
    bus.out_ready = 1'b0;
    vec = '{'h5A};
    run_vec();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
      chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_rec", 64'(dut_rec()), 64'(rec(32'h5A, 1'b0, 1'b0, 1'b0, 1'b0)));
    end
    step();
    bus.out_ready = 1'b1;
    repeat (2) step();

    // Reset mid-sequence with a truncation pending in the output register
    bus.out_ready = 1'b0;
    send_byte(8'hE2);
    send_byte(8'h82);
    send_byte(8'h41);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_out_rec", 64'(dut_rec()), 64'(0));
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_output", 64'(bus.out_valid), 64'(0));
    end
    step();
    vec = '{'h80};
    run_vec();
    @(negedge clk);
    chk("post_rst_lone_cont", 64'(dut_rec()), 64'(rec(REPL, 1'b1, 1'b0, 1'b0, 1'b0)));

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
